i2s_frac_tx: RTL

- Audio serializer directly downstream of the video/audio block's volume-scaled stereo outputs; drives the on-board headphone DAC/amplifier pins hp_bck, hp_ws and hp_din.
- Generates the I2S bit clock from the system/pixel clock with a fractional accumulator, because the clock is not an integer multiple of the sample rate (31.52 MHz PAL, 32.94 MHz NTSC).
- Serializes one signed 16-bit left/right pair per frame in Philips I2S format and pulses a strobe when each new pair is captured.

---
 rtl/i2s_frac_tx_if.sv | 21 ++
 rtl/i2s_frac_tx.sv | 105 ++++++++++
 2 files changed

// File: rtl/i2s_frac_tx_if.sv
// Stereo sample inputs, rate control and I2S pin bundle for i2s_frac_tx.
// master is the serializer side, slave the sample source / DAC side.
interface i2s_frac_tx_if;
    logic        [31:0] clk_rate;
    logic signed [15:0] left_chan;
    logic signed [15:0] right_chan;
    logic               sclk;
    logic               lrclk;
    logic               sdata;
    logic               sample_strobe;

    modport master (
        input  clk_rate, left_chan, right_chan,
        output sclk, lrclk, sdata, sample_strobe
    );

    modport slave (
        output clk_rate, left_chan, right_chan,
        input  sclk, lrclk, sdata, sample_strobe
    );
endinterface

// File: rtl/i2s_frac_tx.sv
// Philips I2S serializer for one signed 16-bit stereo pair per frame; the bit
// clock comes from a fractional accumulator so any clk frequency works.
module i2s_frac_tx #(
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned ACC_W       = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    i2s_frac_tx_if.master bus
);

    localparam int unsigned    INC   = 64 * SAMPLE_RATE;
    localparam logic [ACC_W-1:0] INC_W = ACC_W'(INC);
    localparam int unsigned    CNT_W = 5;
    localparam int unsigned    SR_W  = 32;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sclk_q, sclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             strobe_q, strobe_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [SR_W-1:0]  shreg_q, shreg_d;

    logic [ACC_W-1:0] rate;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] bcnt_nxt;
    logic             tick;

    // Tick generation and bit events; a falling tick (sclk 1->0) advances the frame.
    always_comb begin
        acc_d    = acc_q;
        sclk_d   = sclk_q;
        lrclk_d  = lrclk_q;
        sdata_d  = sdata_q;
        strobe_d = 1'b0;
        run_d    = run_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        tick     = 1'b0;
        bcnt_nxt = bcnt_q;

        rate    = ACC_W'(bus.clk_rate);
        acc_sum = acc_q + INC_W;

        if (rate != '0) begin
            if (acc_sum >= rate) begin
                acc_d = acc_sum - rate;
                tick  = 1'b1;
            end else begin
                acc_d = acc_sum;
            end

            if (tick) begin
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    // The first bit event after reset opens frame 0 rather than counting to 1.
                    bcnt_nxt = run_q ? bcnt_q + CNT_W'(1) : '0;
                    bcnt_d   = bcnt_nxt;
                    run_d    = 1'b1;
                    sdata_d  = shreg_q[SR_W-1];
                    if (bcnt_nxt == '0) begin
                        shreg_d  = {bus.left_chan, bus.right_chan};
                        lrclk_d  = 1'b0;
                        strobe_d = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[SR_W-2:0], 1'b0};
                    end
                    if (bcnt_nxt == CNT_W'(16)) begin
                        lrclk_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            sclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
            bcnt_q   <= '0;
            shreg_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            sclk_q   <= sclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            strobe_q <= strobe_d;
            run_q    <= run_d;
            bcnt_q   <= bcnt_d;
            shreg_q  <= shreg_d;
        end
    end

    assign bus.sclk          = sclk_q;
    assign bus.lrclk         = lrclk_q;
    assign bus.sdata         = sdata_q;
    assign bus.sample_strobe = strobe_q;

endmodule
